fetch_prefetch_unit: RTL and testbench

//  Next-generation RV32IM fetch stage. Holds the fetch PC and issues in-order instruction

---
 rtl/fetch_prefetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_prefetch_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// RV32IM fetch stage: holds the fetch PC, issues in-order imem requests and buffers
// returned words in a DEPTH-entry prefetch FIFO feeding decode.
module fetch_prefetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [XLEN-1:0] EXC_VECTOR = 32'h0000_0100,
    parameter int unsigned     DEPTH      = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      pc_sel,
    input  logic            ex,
    input  logic [XLEN-1:0] pc_dec_in,
    input  logic [XLEN-1:0] pc_alu_in,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, head_pc_q;
    logic [CW-1:0]   count_q, inflight_q, discard_q;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [31:0]     mem_q [DEPTH];

    logic            redir;
    logic [XLEN-1:0] target_raw, target;
    logic [CW:0]     occ_sum, out_sum;
    logic            accept, rsp_drop, rsp_live, push, pop;

    always_comb begin
        redir = ex | (pc_sel != 2'b00);
        target_raw = fetch_pc_q;
        if (ex) begin
            target_raw = EXC_VECTOR;
        end else begin
            unique case (pc_sel)
                2'b11:   target_raw = EXC_VECTOR;
                2'b10:   target_raw = pc_alu_in;
                2'b01:   target_raw = pc_dec_in;
                default: target_raw = fetch_pc_q;
            endcase
        end
        target = {target_raw[XLEN-1:2], 2'b00};

        // Credits cover both FIFO slots and stale words still owed by memory.
        occ_sum = {1'b0, count_q} + {1'b0, inflight_q};
        out_sum = {1'b0, inflight_q} + {1'b0, discard_q};
        imem_req_valid = !rst && !redir && (occ_sum < DEPTH_W) && (out_sum < DEPTH_W);
        imem_req_addr  = fetch_pc_q;
        accept = imem_req_valid && imem_req_ready;

        rsp_drop = imem_rsp_valid && (discard_q != '0);
        rsp_live = imem_rsp_valid && (discard_q == '0) && (inflight_q != '0);
        push     = rsp_live && !redir;

        if_valid    = !rst && (count_q != '0);
        if_instr    = mem_q[rd_ptr_q];
        if_pc       = head_pc_q;
        if_pc_plus4 = head_pc_q + XLEN'(4);
        pop         = if_valid && if_ready && !redir;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else if (redir) begin
            fetch_pc_q <= target;
            head_pc_q  <= target;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= '0;
            // Everything still outstanding becomes stale, minus any word returning now.
            discard_q  <= discard_q + inflight_q - CW'(rsp_drop || rsp_live);
        end else begin
            if (accept) fetch_pc_q <= fetch_pc_q + XLEN'(4);
            inflight_q <= inflight_q + CW'(accept) - CW'(rsp_live);
            discard_q  <= discard_q - CW'(rsp_drop);
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                head_pc_q <= head_pc_q + XLEN'(4);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q] <= imem_rsp_data;
    end

    assert property (@(posedge clk) disable iff (rst) !(push && !pop && count_q == DEPTH_C));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomised and directed bench for fetch_prefetch_unit against a queue-based reference model
// that tags each request with a redirect epoch.
module tb_fetch_prefetch_unit;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_0100;

    logic        clk, rst;
    logic [1:0]  pc_sel;
    logic        ex;
    logic [31:0] pc_dec_in, pc_alu_in;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid, if_ready;
    logic [31:0] if_instr, if_pc, if_pc_plus4;

    fetch_prefetch_unit #(
        .XLEN(32), .RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VEC), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .pc_sel(pc_sel), .ex(ex),
        .pc_dec_in(pc_dec_in), .pc_alu_in(pc_alu_in),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; int ep; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

    req_t        memq[$];
    ent_t        fq[$];
    logic [31:0] m_fetch_pc;
    int          epoch, cyc;
    int          lat_min, lat_max;
    int          n_checks, n_fail;

    logic        exp_req_valid, exp_if_valid, exp_redir;
    logic [31:0] exp_target;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hC0DE_0000;
    endfunction

    function automatic int cur_out();
        int n = 0;
        foreach (memq[i]) if (memq[i].ep == epoch) n++;
        return n;
    endfunction

    // Drive one cycle of inputs at the falling edge and form the model's expectations.
    task automatic set_in(input bit r, input logic [1:0] sel, input bit e,
                          input logic [31:0] dec, input logic [31:0] alu,
                          input bit ifr, input bit rdy);
        rst = r; pc_sel = sel; ex = e; pc_dec_in = dec; pc_alu_in = alu;
        if_ready = ifr; imem_req_ready = rdy;
        imem_rsp_valid = (memq.size() > 0) && (memq[0].due <= cyc);
        imem_rsp_data  = imem_rsp_valid ? word_of(memq[0].addr) : $urandom;
        exp_redir = e || (sel != 2'b00);
        if (e || sel == 2'b11) exp_target = EXC_VEC;
        else if (sel == 2'b10) exp_target = alu;
        else exp_target = dec;
        exp_target[1:0] = 2'b00;
        exp_req_valid = !r && !exp_redir && (fq.size() + cur_out() < DEPTH)
                        && (memq.size() < DEPTH);
        exp_if_valid = !r && (fq.size() > 0);
        #1;
    endtask

    task automatic advance();
        bit acc, rsp, pop;
        req_t q;
        acc = exp_req_valid && imem_req_ready;
        rsp = imem_rsp_valid;
        pop = exp_if_valid && if_ready;
        @(posedge clk);
        if (rst) begin
            memq.delete(); fq.delete();
            m_fetch_pc = RESET_PC;
            epoch++;
        end else begin
            if (rsp) begin
                q = memq.pop_front();
                if (q.ep == epoch && !exp_redir) fq.push_back('{pc: q.addr, data: word_of(q.addr)});
            end
            if (exp_redir) begin
                fq.delete();
                m_fetch_pc = exp_target;
                epoch++;
            end else begin
                if (pop) void'(fq.pop_front());
                if (acc) begin
                    memq.push_back('{addr: m_fetch_pc, due: cyc + $urandom_range(lat_max, lat_min),
                                     ep: epoch});
                    m_fetch_pc += 32'd4;
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input bit ifr, input bit rdy);
        set_in(0, 2'b00, 0, 32'h0, 32'h0, ifr, rdy);
    endtask

    task automatic do_reset();
        repeat (2) begin
            set_in(1, 2'b00, 0, 32'h0, 32'h0, 0, 1);
            advance();
        end
    endtask

    task automatic test_reset();
        repeat (2) begin
            set_in(1, 2'b00, 0, 32'h0, 32'h0, 1, 1);
            n_checks++;
            if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: req_valid=%b if_valid=%b, required 0 0",
                         imem_req_valid, if_valid);
            end
            advance();
        end
        idle(0, 1);
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL reset_first_req: valid=%b addr=%h, required 1 %h",
                     imem_req_valid, imem_req_addr, RESET_PC);
        end
        n_checks++;
        if (if_pc !== RESET_PC) begin
            n_fail++;
            $display("FAIL reset_head_pc: if_pc=%h, required %h", if_pc, RESET_PC);
        end
        advance();
    endtask

    task automatic test_sequential();
        logic [31:0] nxt = RESET_PC;
        int pops = 0;
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (14) begin
            idle(1, 1);
            if (if_valid && if_ready) begin
                n_checks++;
                if (if_pc !== nxt || if_instr !== word_of(nxt) || if_pc_plus4 !== nxt + 32'd4) begin
                    n_fail++;
                    $display("FAIL seq_pop: pc=%h instr=%h pc4=%h, required %h %h %h",
                             if_pc, if_instr, if_pc_plus4, nxt, word_of(nxt), nxt + 32'd4);
                end
                nxt += 32'd4;
                pops++;
            end
            advance();
        end
        n_checks++;
        if (pops < 10) begin
            n_fail++;
            $display("FAIL seq_throughput: pops=%0d, required >= 10", pops);
        end
    endtask

    task automatic test_backpressure();
        int n_acc = 0;
        bit resumed = 0;
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (10) begin
            idle(0, 1);
            if (imem_req_valid && imem_req_ready) n_acc++;
            advance();
        end
        idle(0, 1);
        n_checks++;
        if (n_acc != DEPTH || imem_req_valid !== 1'b0 || if_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_full: accepts=%0d req_valid=%b if_valid=%b, required %0d 0 1",
                     n_acc, imem_req_valid, if_valid, DEPTH);
        end
        for (int i = 0; i < 4 && !resumed; i++) begin
            idle(1, 1);
            if (imem_req_valid) resumed = 1;
            advance();
        end
        n_checks++;
        if (!resumed) begin
            n_fail++;
            $display("FAIL bp_resume: req_valid stayed 0 within 4 cycles, required 1");
        end
    endtask

    task automatic test_redirect();
        bit seen = 0;
        lat_min = 3; lat_max = 3;
        do_reset();
        repeat (3) begin idle(1, 1); advance(); end
        set_in(0, 2'b10, 0, 32'h0, 32'h200, 1, 1);
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_req_blocked: req_valid=%b, required 0", imem_req_valid);
        end
        advance();
        for (int i = 0; i < 20 && !seen; i++) begin
            idle(1, 1);
            if (if_valid) begin
                seen = 1;
                n_checks++;
                if (if_pc !== 32'h200 || if_instr !== word_of(32'h200)) begin
                    n_fail++;
                    $display("FAIL redir_first: pc=%h instr=%h, required %h %h",
                             if_pc, if_instr, 32'h200, word_of(32'h200));
                end
            end
            advance();
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL redir_timeout: no if_valid within 20 cycles, required 1");
        end
    endtask

    task automatic test_priority();
        lat_min = 1; lat_max = 2;
        do_reset();
        set_in(0, 2'b01, 1, 32'h40, 32'h0, 0, 1);
        advance();
        idle(0, 0);
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== EXC_VEC) begin
            n_fail++;
            $display("FAIL prio_ex: valid=%b addr=%h, required 1 %h",
                     imem_req_valid, imem_req_addr, EXC_VEC);
        end
        advance();
        set_in(0, 2'b10, 0, 32'h40, 32'h203, 0, 1);
        advance();
        idle(0, 1);
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL prio_alu_align: valid=%b addr=%h, required 1 00000200",
                     imem_req_valid, imem_req_addr);
        end
        advance();
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] nxt = RESET_PC;
        lat_min = 2; lat_max = 2;
        do_reset();
        repeat (5) begin idle(1, 1); advance(); end
        set_in(1, 2'b00, 0, 32'h0, 32'h0, 1, 1);
        n_checks++;
        if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs: req_valid=%b if_valid=%b, required 0 0",
                     imem_req_valid, if_valid);
        end
        advance();
        idle(1, 1);
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC || if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_restart: valid=%b addr=%h if_valid=%b, required 1 %h 0",
                     imem_req_valid, imem_req_addr, if_valid, RESET_PC);
        end
        advance();
        repeat (10) begin
            idle(1, 1);
            if (if_valid) begin
                n_checks++;
                if (if_pc !== nxt || if_instr !== word_of(nxt)) begin
                    n_fail++;
                    $display("FAIL midrst_order: pc=%h instr=%h, required %h %h",
                             if_pc, if_instr, nxt, word_of(nxt));
                end
                nxt += 32'd4;
            end
            advance();
        end
    endtask

    task automatic test_random();
        bit r, e;
        logic [1:0] sel;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            lat_min = 1; lat_max = 4;
            r   = ($urandom_range(199) == 0);
            e   = ($urandom_range(49) == 0);
            sel = ($urandom_range(19) == 0) ? 2'($urandom) : 2'b00;
            set_in(r, sel, e, $urandom, (i % 97 == 0) ? 32'hFFFF_FFFC : $urandom,
                   $urandom_range(3) != 0, $urandom_range(3) != 0);
            n_checks++;
            if (imem_req_valid !== exp_req_valid
                || (exp_req_valid && imem_req_addr !== m_fetch_pc)) begin
                n_fail++;
                $display("FAIL rand_req cyc=%0d: valid=%b addr=%h, required %b %h",
                         cyc, imem_req_valid, imem_req_addr, exp_req_valid, m_fetch_pc);
            end
            n_checks++;
            if (if_valid !== exp_if_valid) begin
                n_fail++;
                $display("FAIL rand_if_valid cyc=%0d: %b, required %b",
                         cyc, if_valid, exp_if_valid);
            end else if (exp_if_valid) begin
                n_checks++;
                if (if_pc !== fq[0].pc || if_instr !== fq[0].data
                    || if_pc_plus4 !== fq[0].pc + 32'd4) begin
                    n_fail++;
                    $display("FAIL rand_head cyc=%0d: pc=%h instr=%h pc4=%h, required %h %h %h",
                             cyc, if_pc, if_instr, if_pc_plus4, fq[0].pc, fq[0].data,
                             fq[0].pc + 32'd4);
                end
            end
            advance();
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; epoch = 0;
        lat_min = 1; lat_max = 1;
        m_fetch_pc = RESET_PC;
        rst = 1; pc_sel = 2'b00; ex = 0; pc_dec_in = '0; pc_alu_in = '0;
        if_ready = 0; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_priority();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
